// File: rtl/bpu_pkg.sv
// Shared defaults and reset-value helper for the tournament branch predictor.
package bpu_pkg;

  localparam int unsigned PHT_INDEX_BITS_DEF = 10;
  localparam int unsigned BHT_INDEX_BITS_DEF = 3;
  localparam int unsigned CTR_BITS_DEF       = 2;
  localparam int unsigned CNT_BITS_DEF       = 32;

  // Weakly-not-taken counter value: one below the taken threshold.
  function automatic int unsigned weak_nt(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/tournament_bpu_if.sv
// F-stage prediction and E-stage resolution signals between pipeline and predictor.
interface tournament_bpu_if
  import bpu_pkg::*;
#(
  parameter int unsigned PHT_INDEX_BITS = PHT_INDEX_BITS_DEF,
  parameter int unsigned BHT_INDEX_BITS = BHT_INDEX_BITS_DEF,
  parameter int unsigned CNT_BITS       = CNT_BITS_DEF
) ();

  logic [31:0]               pcF;
  logic                      predict_takeF;
  logic                      local_predF;
  logic                      global_predF;
  logic [BHT_INDEX_BITS-1:0] bht_idxF;
  logic [PHT_INDEX_BITS-1:0] local_idxF;
  logic [PHT_INDEX_BITS-1:0] global_idxF;

  logic                      branchE;
  logic                      actually_takenE;
  logic [BHT_INDEX_BITS-1:0] bht_idxE;
  logic [PHT_INDEX_BITS-1:0] local_idxE;
  logic [PHT_INDEX_BITS-1:0] global_idxE;
  logic                      local_predE;
  logic                      global_predE;
  logic                      predict_takeE;
  logic                      mispredictE;

  logic [CNT_BITS-1:0]       branch_count;
  logic [CNT_BITS-1:0]       mispredict_count;

  modport master (
    output pcF, branchE, actually_takenE, bht_idxE, local_idxE, global_idxE,
           local_predE, global_predE, predict_takeE,
    input  predict_takeF, local_predF, global_predF, bht_idxF, local_idxF,
           global_idxF, mispredictE, branch_count, mispredict_count
  );

  modport slave (
    input  pcF, branchE, actually_takenE, bht_idxE, local_idxE, global_idxE,
           local_predE, global_predE, predict_takeE,
    output predict_takeF, local_predF, global_predF, bht_idxF, local_idxF,
           global_idxF, mispredictE, branch_count, mispredict_count
  );

endinterface

// File: rtl/pht_table.sv
// Table of saturating counters: one async read port (MSB only), one update port.
module pht_table
  import bpu_pkg::*;
#(
  parameter int unsigned IDX_BITS = PHT_INDEX_BITS_DEF,
  parameter int unsigned CTR_BITS = CTR_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_msb_o,
  input  logic                upd_en_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_inc_i
);

  localparam int unsigned       DEPTH   = 32'd1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(weak_nt(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] cur_c;
  logic [CTR_BITS-1:0] ctr_d;

  assign rd_msb_o = ctr_q[rd_idx_i][CTR_BITS-1];

  // Saturating step of the addressed entry.
  always_comb begin
    cur_c = ctr_q[upd_idx_i];
    ctr_d = cur_c;
    if (upd_inc_i) begin
      if (cur_c != CTR_MAX) ctr_d = cur_c + CTR_BITS'(1);
    end else begin
      if (cur_c != '0) ctr_d = cur_c - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/tournament_bpu.sv
// Tournament predictor: local (BHT+LPHT) vs gshare (GHR+GPHT), picked by a chooser PHT.
module tournament_bpu
  import bpu_pkg::*;
#(
  parameter int unsigned PHT_INDEX_BITS = PHT_INDEX_BITS_DEF,
  parameter int unsigned BHT_INDEX_BITS = BHT_INDEX_BITS_DEF,
  parameter int unsigned CTR_BITS       = CTR_BITS_DEF,
  parameter int unsigned CNT_BITS       = CNT_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  output logic                      predict_takeF,
  output logic                      local_predF,
  output logic                      global_predF,
  output logic [BHT_INDEX_BITS-1:0] bht_idxF,
  output logic [PHT_INDEX_BITS-1:0] local_idxF,
  output logic [PHT_INDEX_BITS-1:0] global_idxF,
  input  logic                      branchE,
  input  logic                      actually_takenE,
  input  logic [BHT_INDEX_BITS-1:0] bht_idxE,
  input  logic [PHT_INDEX_BITS-1:0] local_idxE,
  input  logic [PHT_INDEX_BITS-1:0] global_idxE,
  input  logic                      local_predE,
  input  logic                      global_predE,
  input  logic                      predict_takeE,
  output logic                      mispredictE,
  output logic [CNT_BITS-1:0]       branch_count,
  output logic [CNT_BITS-1:0]       mispredict_count
);

  localparam int unsigned BHT_DEPTH = 32'd1 << BHT_INDEX_BITS;

  logic [PHT_INDEX_BITS-1:0] bht_q [BHT_DEPTH];
  logic [PHT_INDEX_BITS-1:0] ghr_q;
  logic [CNT_BITS-1:0]       branch_cnt_q;
  logic [CNT_BITS-1:0]       mispred_cnt_q;
  logic                      choose_global_c;
  logic                      chooser_upd_c;
  logic                      unused_pc_c;

  // PC bits above the largest index and the byte offset do not index anything.
  assign unused_pc_c = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0]};

  assign bht_idxF      = pcF[BHT_INDEX_BITS+1:2];
  assign local_idxF    = bht_q[bht_idxF];
  assign global_idxF   = ghr_q ^ pcF[PHT_INDEX_BITS+1:2];
  assign predict_takeF = choose_global_c ? global_predF : local_predF;

  assign mispredictE   = branchE & (predict_takeE ^ actually_takenE);
  assign chooser_upd_c = branchE & (local_predE ^ global_predE);

  pht_table #(.IDX_BITS(PHT_INDEX_BITS), .CTR_BITS(CTR_BITS)) u_lpht (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx_i  (local_idxF),
    .rd_msb_o  (local_predF),
    .upd_en_i  (branchE),
    .upd_idx_i (local_idxE),
    .upd_inc_i (actually_takenE)
  );

  pht_table #(.IDX_BITS(PHT_INDEX_BITS), .CTR_BITS(CTR_BITS)) u_gpht (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx_i  (global_idxF),
    .rd_msb_o  (global_predF),
    .upd_en_i  (branchE),
    .upd_idx_i (global_idxE),
    .upd_inc_i (actually_takenE)
  );

  // Chooser moves toward global when global was the correct component.
  pht_table #(.IDX_BITS(PHT_INDEX_BITS), .CTR_BITS(CTR_BITS)) u_cpht (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx_i  (global_idxF),
    .rd_msb_o  (choose_global_c),
    .upd_en_i  (chooser_upd_c),
    .upd_idx_i (global_idxE),
    .upd_inc_i (global_predE == actually_takenE)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= '0;
      ghr_q <= '0;
    end else if (branchE) begin
      bht_q[bht_idxE] <= {bht_q[bht_idxE][PHT_INDEX_BITS-2:0], actually_takenE};
      ghr_q           <= {ghr_q[PHT_INDEX_BITS-2:0], actually_takenE};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (branchE && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + CNT_BITS'(1);
      if (mispredictE && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_BITS'(1);
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_tournament_bpu.sv
// Randomized bench for tournament_bpu against an integer-array reference model.
module tb_tournament_bpu;

  localparam int unsigned PHT = 10;
  localparam int unsigned BHT = 3;
  localparam int unsigned CTR = 2;
  localparam int unsigned CNT = 4;
  localparam int PSZ  = 1 << PHT;
  localparam int BSZ  = 1 << BHT;
  localparam int CMAX = (1 << CTR) - 1;
  localparam int SMAX = (1 << CNT) - 1;
  localparam int WNT  = (1 << (CTR - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tournament_bpu_if #(.PHT_INDEX_BITS(PHT), .BHT_INDEX_BITS(BHT), .CNT_BITS(CNT)) bif ();

  tournament_bpu #(.PHT_INDEX_BITS(PHT), .BHT_INDEX_BITS(BHT),
                   .CTR_BITS(CTR), .CNT_BITS(CNT)) dut (
    .clk              (clk),
    .rst              (rst),
    .pcF              (bif.pcF),
    .predict_takeF    (bif.predict_takeF),
    .local_predF      (bif.local_predF),
    .global_predF     (bif.global_predF),
    .bht_idxF         (bif.bht_idxF),
    .local_idxF       (bif.local_idxF),
    .global_idxF      (bif.global_idxF),
    .branchE          (bif.branchE),
    .actually_takenE  (bif.actually_takenE),
    .bht_idxE         (bif.bht_idxE),
    .local_idxE       (bif.local_idxE),
    .global_idxE      (bif.global_idxE),
    .local_predE      (bif.local_predE),
    .global_predE     (bif.global_predE),
    .predict_takeE    (bif.predict_takeE),
    .mispredictE      (bif.mispredictE),
    .branch_count     (bif.branch_count),
    .mispredict_count (bif.mispredict_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integer tables and histories.
  int lpht_m [PSZ];
  int gpht_m [PSZ];
  int cpht_m [PSZ];
  int bht_m  [BSZ];
  int ghr_m, bc_m, mc_m;

  task automatic model_reset();
    for (int i = 0; i < PSZ; i++) begin
      lpht_m[i] = WNT; gpht_m[i] = WNT; cpht_m[i] = WNT;
    end
    for (int i = 0; i < BSZ; i++) bht_m[i] = 0;
    ghr_m = 0; bc_m = 0; mc_m = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output bit pt, output bit lp,
                               output bit gp, output int bidx, output int lidx,
                               output int gidx);
    bidx = int'(pc >> 2) % BSZ;
    lidx = bht_m[bidx];
    gidx = ghr_m ^ (int'(pc >> 2) % PSZ);
    lp   = lpht_m[lidx] > WNT;
    gp   = gpht_m[gidx] > WNT;
    pt   = (cpht_m[gidx] > WNT) ? gp : lp;
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_update(input bit br, input bit tk, input bit lp, input bit gp,
                              input bit pt, input int bidx, input int lidx, input int gidx);
    int step;
    if (!br) return;
    step = tk ? 1 : -1;
    lpht_m[lidx] = clamp(lpht_m[lidx] + step, CMAX);
    gpht_m[gidx] = clamp(gpht_m[gidx] + step, CMAX);
    if (lp != gp) cpht_m[gidx] = clamp(cpht_m[gidx] + ((gp == tk) ? 1 : -1), CMAX);
    bht_m[bidx] = (bht_m[bidx] * 2 + int'(tk)) % PSZ;
    ghr_m       = (ghr_m * 2 + int'(tk)) % PSZ;
    bc_m = clamp(bc_m + 1, SMAX);
    if (pt != tk) mc_m = clamp(mc_m + 1, SMAX);
  endtask

  task automatic drive_e(input bit br, input bit tk, input bit lp, input bit gp,
                         input bit pt, input int bidx, input int lidx, input int gidx);
    bif.branchE         = br;
    bif.actually_takenE = tk;
    bif.local_predE     = lp;
    bif.global_predE    = gp;
    bif.predict_takeE   = pt;
    bif.bht_idxE        = BHT'(bidx);
    bif.local_idxE      = PHT'(lidx);
    bif.global_idxE     = PHT'(gidx);
  endtask

  // Drives one E-stage resolution across a rising edge and mirrors it in the model.
  task automatic resolve(input bit tk, input bit lp, input bit gp, input bit pt,
                         input int bidx, input int lidx, input int gidx);
    @(negedge clk);
    drive_e(1'b1, tk, lp, gp, pt, bidx, lidx, gidx);
    @(posedge clk);
    model_update(1'b1, tk, lp, gp, pt, bidx, lidx, gidx);
    #1 drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    bif.pcF = 32'h0040_0000;
    #1;
    checks++;
    if (bif.predict_takeF !== 1'b0 || bif.branch_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_pred: pred=%b bc=%0d, want pred=0 bc=0",
               bif.predict_takeF, bif.branch_count);
    end
    checks++;
    if ({bif.local_predF, bif.global_predF, bif.local_idxF, bif.global_idxF,
         bif.mispredict_count} !== {1'b0, 1'b0, 10'd0, 10'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_idx: lp=%b gp=%b lidx=%0d gidx=%0d mc=%0d, want all 0",
               bif.local_predF, bif.global_predF, bif.local_idxF, bif.global_idxF,
               bif.mispredict_count);
    end
  endtask

  task automatic test_training();
    logic [31:0] pc = 32'h0040_0104;
    bit pt, lp, gp;
    int bi, li, gi, mc_before;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      bif.pcF = pc;
      #1 model_predict(pc, pt, lp, gp, bi, li, gi);
      checks++;
      if (bif.predict_takeF !== pt || bif.local_idxF !== PHT'(li) || bif.global_idxF !== PHT'(gi)) begin
        failures++;
        $display("FAIL train_iter%0d: pred=%b lidx=%0d gidx=%0d, want %b %0d %0d",
                 n, bif.predict_takeF, bif.local_idxF, bif.global_idxF, pt, li, gi);
      end
      resolve(1'b1, lp, gp, pt, bi, li, gi);
    end
    @(negedge clk);
    bif.pcF = pc;
    #1;
    checks++;
    if (bif.predict_takeF !== 1'b1) begin
      failures++;
      $display("FAIL train_pred: pred=%b, want 1", bif.predict_takeF);
    end
    model_predict(pc, pt, lp, gp, bi, li, gi);
    mc_before = mc_m;
    resolve(1'b1, lp, gp, pt, bi, li, gi);
    checks++;
    if (int'(bif.mispredict_count) != mc_before || mc_before != 11 || int'(bif.branch_count) != 13) begin
      failures++;
      $display("FAIL train_mc: mc=%0d bc=%0d, want mc=11 bc=13",
               bif.mispredict_count, bif.branch_count);
    end
  endtask

  task automatic test_saturation();
    int gi = 'h155;
    do_reset();
    for (int n = 0; n < 5; n++) resolve(1'b1, 1'b0, 1'b0, 1'b0, 2, 7, gi);
    checks++;
    if (dut.u_gpht.ctr_q[gi] !== 2'd3) begin
      failures++;
      $display("FAIL sat_up: gpht=%0d, want 3", dut.u_gpht.ctr_q[gi]);
    end
    resolve(1'b0, 1'b0, 1'b0, 1'b0, 2, 7, gi);
    checks++;
    if (dut.u_gpht.ctr_q[gi] !== 2'd2) begin
      failures++;
      $display("FAIL sat_down: gpht=%0d, want 2", dut.u_gpht.ctr_q[gi]);
    end
    @(negedge clk);
    bif.pcF = 32'h0040_0000 | (32'((gi ^ ghr_m) % PSZ) << 2);
    #1;
    checks++;
    if (bif.global_predF !== 1'b1 || bif.global_idxF !== PHT'(gi)) begin
      failures++;
      $display("FAIL sat_pred: gp=%b gidx=%0d, want gp=1 gidx=%0d",
               bif.global_predF, bif.global_idxF, gi);
    end
  endtask

  task automatic test_chooser();
    int gi = 'h0A7;
    do_reset();
    resolve(1'b0, 1'b1, 1'b0, 1'b1, 5, 33, gi);
    checks++;
    if (dut.u_cpht.ctr_q[gi] !== 2'd2) begin
      failures++;
      $display("FAIL chooser_step: cpht=%0d, want 2", dut.u_cpht.ctr_q[gi]);
    end
    resolve(1'b0, 1'b1, 1'b1, 1'b1, 5, 33, gi);
    checks++;
    if (dut.u_cpht.ctr_q[gi] !== 2'd2) begin
      failures++;
      $display("FAIL chooser_hold: cpht=%0d, want 2", dut.u_cpht.ctr_q[gi]);
    end
  endtask

  task automatic test_stats_sat();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      drive_e(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, n % BSZ, n, n * 3);
      #1;
      checks++;
      if (bif.mispredictE !== 1'b1) begin
        failures++;
        $display("FAIL stats_mispE%0d: got %b, want 1", n, bif.mispredictE);
      end
      @(posedge clk);
      #1;
    end
    drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (bif.branch_count !== 4'd15 || bif.mispredict_count !== 4'd15) begin
      failures++;
      $display("FAIL stats_sat: bc=%0d mc=%0d, want 15 15",
               bif.branch_count, bif.mispredict_count);
    end
  endtask

  // Random traffic over a small PC set; checks F outputs, mispredictE and counters.
  task automatic test_random(input int n_iter);
    logic [31:0] pc;
    bit pt, lp, gp, br, tk;
    int bi, li, gi;
    for (int n = 0; n < n_iter; n++) begin
      @(negedge clk);
      pc = 32'h0040_0000 | 32'($urandom_range(0, 63) << 2);
      bif.pcF = pc;
      #1 model_predict(pc, pt, lp, gp, bi, li, gi);
      checks++;
      if ({bif.predict_takeF, bif.local_predF, bif.global_predF, bif.bht_idxF,
           bif.local_idxF, bif.global_idxF} !== {pt, lp, gp, BHT'(bi), PHT'(li), PHT'(gi)}) begin
        failures++;
        $display("FAIL rand_f%0d: pt=%b lp=%b gp=%b b=%0d l=%0d g=%0d, want %b %b %b %0d %0d %0d",
                 n, bif.predict_takeF, bif.local_predF, bif.global_predF, bif.bht_idxF,
                 bif.local_idxF, bif.global_idxF, pt, lp, gp, bi, li, gi);
      end
      br = $urandom_range(0, 4) != 0;
      tk = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) pt = 1'($urandom_range(0, 1));
      drive_e(br, tk, lp, gp, pt, bi, li, gi);
      #1;
      checks++;
      if (bif.mispredictE !== (br && (pt != tk))) begin
        failures++;
        $display("FAIL rand_misp%0d: got %b, want %b", n, bif.mispredictE, br && (pt != tk));
      end
      @(posedge clk);
      model_update(br, tk, lp, gp, pt, bi, li, gi);
      #1;
      checks++;
      if (int'(bif.branch_count) != bc_m || int'(bif.mispredict_count) != mc_m) begin
        failures++;
        $display("FAIL rand_cnt%0d: bc=%0d mc=%0d, want %0d %0d",
                 n, bif.branch_count, bif.mispredict_count, bc_m, mc_m);
      end
      drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    test_random(60);
    @(negedge clk);
    drive_e(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 5, 9);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    model_reset();
    #1;
    bad = 0;
    for (int i = 0; i < PSZ; i++) begin
      if (int'(dut.u_lpht.ctr_q[i]) != WNT) bad++;
      if (int'(dut.u_gpht.ctr_q[i]) != WNT) bad++;
      if (int'(dut.u_cpht.ctr_q[i]) != WNT) bad++;
    end
    for (int i = 0; i < BSZ; i++) if (dut.bht_q[i] !== '0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_tables: %0d entries off reset value, want 0", bad);
    end
    checks++;
    if (dut.ghr_q !== '0 || bif.branch_count !== 4'd0 || bif.mispredict_count !== 4'd0) begin
      failures++;
      $display("FAIL midrst_state: ghr=%0d bc=%0d mc=%0d, want 0 0 0",
               dut.ghr_q, bif.branch_count, bif.mispredict_count);
    end
    test_random(40);
  endtask

  initial begin
    bif.pcF = 32'h0040_0000;
    drive_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    model_reset();
    test_reset();
    test_training();
    test_saturation();
    test_chooser();
    test_stats_sat();
    do_reset();
    test_random(300);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
